// File: rtl/block_summer.sv
// ---------------------------------------------------------------------------
// block_summer
//   Collects N_WORDS 16-bit words from an upstream FIFO, then presents the
//   unsigned 20-bit sum and the largest word of that block to a downstream
//   consumer. There are two states. ACC accepts words. OUT holds one result
//   until the downstream side takes it.
//
// Parameters
//   N_WORDS       words per block, legal range 2..16
//
// Ports
//   clk           single clock, rising edge
//   rstn          asynchronous active-low reset
//   data_in       word from the upstream FIFO
//   input_valid   upstream word present
//   input_enable  block can accept a word (state == ACC)
//   data_out      sum of the last completed block
//   data_max      largest word of the last completed block
//   output_valid  data_out / data_max hold an untaken result (state == OUT)
//   output_enable downstream accepts the result
// ---------------------------------------------------------------------------
module block_summer #(
  parameter int N_WORDS = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [15:0] data_in,
  input  logic        input_valid,
  output logic        input_enable,
  output logic [19:0] data_out,
  output logic [15:0] data_max,
  output logic        output_valid,
  input  logic        output_enable
);

  localparam int CNT_W = (N_WORDS > 2) ? $clog2(N_WORDS) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_WORDS - 1);

  typedef enum logic {
    ST_ACC = 1'b0,
    ST_OUT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [19:0]      acc_q,   acc_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [15:0]      max_q,   max_d;
  logic [19:0]      sum_q,   sum_d;
  logic [15:0]      dmax_q,  dmax_d;

  // These values are built from data_in on every cycle. They are only used
  // on an accepted transfer, so X on data_in during idle cycles never reaches
  // any state.
  logic [19:0] sum_next;
  logic [15:0] max_next;

  assign sum_next = acc_q + {4'b0000, data_in};
  assign max_next = (data_in > max_q) ? data_in : max_q;

  always_comb begin
    // NOTE: every variable starts from its held value, so no path through the
    // case below leaves a variable unassigned and no latch is inferred.
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    max_d   = max_q;
    sum_d   = sum_q;
    dmax_d  = dmax_q;

    case (state_q)
      ST_ACC: begin
        if (input_valid) begin
          if (cnt_q == LAST_IDX) begin
            // The last word goes straight into the result registers. This
            // gives one-cycle latency and leaves the accumulator clean for
            // the next block.
            sum_d   = sum_next;
            dmax_d  = max_next;
            acc_d   = '0;
            cnt_d   = '0;
            max_d   = '0;
            state_d = ST_OUT;
          end else begin
            acc_d = sum_next;
            max_d = max_next;
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_OUT: begin
        if (output_enable) state_d = ST_ACC;
      end
      default: state_d = ST_ACC;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_ACC;
      acc_q   <= '0;
      cnt_q   <= '0;
      max_q   <= '0;
      sum_q   <= '0;
      dmax_q  <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      max_q   <= max_d;
      sum_q   <= sum_d;
      dmax_q  <= dmax_d;
    end
  end

  // Handshake outputs come only from the state flop. There is no
  // combinational path from any input to any output.
  assign input_enable = (state_q == ST_ACC);
  assign output_valid = (state_q == ST_OUT);
  assign data_out     = sum_q;
  assign data_max     = dmax_q;

endmodule

// File: doc/block_summer.md
BLOCK_SUMMER -- requirements
Module: block_summer

Interface
REQ-001 The module SHALL have parameter N_WORDS, default 4, meaning the number of 16-bit words summed per block; legal range 2..16.
REQ-002 The module SHALL have port clk, input, 1 bit: single clock; all state changes on rising edge.
REQ-003 The module SHALL have port rstn, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The module SHALL have port data_in, input, 16 bits: word from the upstream fifo data_out.
REQ-005 The module SHALL have port input_valid, input, 1 bit: upstream word present; driven by the fifo output_valid.
REQ-006 The module SHALL have port input_enable, output, 1 bit: block can accept a word; drives the fifo output_enable.
REQ-007 The module SHALL have port data_out, output, 20 bits: unsigned sum of the last completed block.
REQ-008 The module SHALL have port data_max, output, 16 bits: largest word of the last completed block.
REQ-009 The module SHALL have port output_valid, output, 1 bit: data_out and data_max hold a result.
REQ-010 The module SHALL have port output_enable, input, 1 bit: downstream accepts the result.

Function
REQ-011 An input transfer SHALL occur on a rising edge where input_valid=1 and input_enable=1; no other edge changes the accumulator.
REQ-012 An output transfer SHALL occur on a rising edge where output_valid=1 and output_enable=1.
REQ-013 The block SHALL implement two states: ACC (collecting words) and OUT (holding a result).
REQ-014 input_enable SHALL be 1 exactly when state=ACC, and output_valid SHALL be 1 exactly when state=OUT; both decode from state only, with no combinational input-to-output path.
REQ-015 In ACC, each input transfer SHALL add zero-extended data_in to a 20-bit accumulator, update the running max (unsigned compare), and increment a word counter.
REQ-016 On the input transfer that is word N_WORDS of a block, the block SHALL load data_out with accumulator+data_in and data_max with max(running max, data_in), clear accumulator, counter and running max, and enter OUT.
REQ-017 Latency SHALL be one cycle: output_valid is 1 on the cycle immediately after the edge that accepted the last word.
REQ-018 In OUT, data_out and data_max SHALL remain stable; input_valid and data_in SHALL be ignored.
REQ-019 In OUT, an output transfer SHALL return the state to ACC, giving input_enable=1 on the next cycle; data_out and data_max keep their values until the next block completes.
REQ-020 In ACC, output_enable SHALL be ignored.
REQ-021 The sum SHALL never overflow: 16*0xFFFF < 2^20, so no saturation or wrap logic is required.
REQ-022 Idle cycles (input_valid=0) inside a block SHALL NOT affect the sum, max or count; data_in values on those cycles SHALL be ignored, including X.
REQ-023 Throughput SHALL be one block per N_WORDS+1 cycles at best: N_WORDS accept cycles plus one OUT cycle.

Reset
REQ-024 While rstn=0, state SHALL be ACC; accumulator, counter and running max SHALL be 0; data_out SHALL be 0x00000; data_max SHALL be 0x0000; output_valid SHALL be 0; input_enable SHALL be 1.
REQ-025 Reset asserted mid-block or in OUT SHALL discard the partial block or the pending result immediately, without waiting for a clock edge.
REQ-026 After rstn deasserts, the first accepted word SHALL be word 1 of a new block.

Verification (N_WORDS=4)
REQ-027 The bench SHALL cover reset: pulse rstn low asynchronously between edges -> output_valid=0, data_out=0x00000, data_max=0x0000 and input_enable=1 immediately.
REQ-028 The bench SHALL cover a back-to-back block: words 0x0001, 0x0002, 0x0003, 0x0004 with input_valid=1 on consecutive edges -> next cycle output_valid=1, data_out=0x0000A, data_max=0x0004, input_enable=0.
REQ-029 The bench SHALL cover the maximum sum: four words of 0xFFFF -> data_out=0x3FFFC and data_max=0xFFFF.
REQ-030 The bench SHALL cover backpressure: hold output_enable=0 for 5 cycles in OUT while input_valid=1 with changing data_in -> data_out is stable, input_enable=0 and no word is absorbed; on raising output_enable, input_enable=1 one cycle later.
REQ-031 The bench SHALL cover gaps: words 0x1000, 0x0010, 0x8000, 0x0001 with randomized input_valid gaps and X on data_in during the gaps -> data_out=0x09011 and data_max=0x8000.
REQ-032 The bench SHALL cover reset mid-block: reset after 2 accepted words, then send 0x0005 x4 -> data_out=0x00014 and data_max=0x0005.
